// File: rtl/bus_pkg.sv
// Shared types for the read-channel arbiter: FSM state encoding and master indices.
package bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_RESP
  } rd_arb_state_e;

  localparam int M_FETCH = 0;
  localparam int M_DATA  = 1;

endpackage

// File: rtl/arb2_pick.sv
// Combinational two-requester winner selection: round-robin or m1-priority with a fetch
// starvation override.
module arb2_pick #(
  parameter int PRIO_MODE = 0
) (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  input  logic       starve_hit_i,
  output logic       grant_valid_o,
  output logic       grant_idx_o
);

  always_comb begin
    grant_valid_o = |req_i;
    grant_idx_o   = req_i[1] & ~req_i[0];
    if (&req_i) begin
      if (PRIO_MODE == 0) grant_idx_o = ~last_grant_i;
      else                grant_idx_o = ~starve_hit_i;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI4-Lite read arbiter (fetch = m0, data = m1), one outstanding read.
// state  | meaning
// S_IDLE | no transaction; arbitrate and grant on any arvalid
// S_ADDR | registered address presented to slave until s_arready
// S_RESP | slave response routed to the granted master until r handshake
module axi_rd_arbiter
  import bus_pkg::*;
#(
  parameter int PRIO_MODE  = 0,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m0_araddr,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  output logic [31:0] m0_rdata,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  input  logic [31:0] m1_araddr,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  output logic [31:0] m1_rdata,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  output logic [31:0] s_araddr,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic [31:0] s_rdata,
  input  logic        s_rvalid,
  output logic        s_rready
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  rd_arb_state_e state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_grant_q, last_grant_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   araddr_q, araddr_d;

  logic pick_valid;
  logic pick_idx;
  logic starve_hit;

  assign starve_hit = (starve_q == SW'(STARVE_MAX));

  arb2_pick #(
    .PRIO_MODE(PRIO_MODE)
  ) u_pick (
    .req_i        ({m1_arvalid, m0_arvalid}),
    .last_grant_i (last_grant_q),
    .starve_hit_i (starve_hit),
    .grant_valid_o(pick_valid),
    .grant_idx_o  (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      starve_q     <= '0;
      araddr_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      starve_q     <= starve_d;
      araddr_q     <= araddr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    starve_d     = starve_q;
    araddr_d     = araddr_q;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d      = S_ADDR;
          grant_d      = pick_idx;
          last_grant_d = pick_idx;
          araddr_d     = pick_idx ? m1_araddr : m0_araddr;
          // Counter only moves in priority mode; it stays 0 under round-robin.
          if (PRIO_MODE == 1) begin
            if (!pick_idx)                    starve_d = '0;
            else if (m0_arvalid && !starve_hit) starve_d = starve_q + SW'(1);
          end
        end
      end
      S_ADDR:  if (s_arready) state_d = S_RESP;
      S_RESP:  if (s_rvalid && s_rready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign m0_arready = (state_q == S_IDLE) && pick_valid && (pick_idx == 1'(M_FETCH));
  assign m1_arready = (state_q == S_IDLE) && pick_valid && (pick_idx == 1'(M_DATA));
  assign s_arvalid  = (state_q == S_ADDR);
  assign s_araddr   = araddr_q;
  assign m0_rvalid  = (state_q == S_RESP) && (grant_q == 1'(M_FETCH)) && s_rvalid;
  assign m1_rvalid  = (state_q == S_RESP) && (grant_q == 1'(M_DATA)) && s_rvalid;
  assign s_rready   = (state_q == S_RESP) && (grant_q ? m1_rready : m0_rready);
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: a round-robin instance and a priority instance
// (STARVE_MAX=2), each attached to an SRAM-like read slave returning 0xA000_0000 + addr.
module tb_axi_rd_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]  m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [1:0]  m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [31:0] m0_araddr [2];
  logic [31:0] m1_araddr [2];
  logic [31:0] m0_rdata  [2];
  logic [31:0] m1_rdata  [2];
  logic [31:0] s_araddr  [2];
  logic [31:0] sl_rdata  [2];
  logic [1:0]  s_arvalid, s_arready, s_rready, sl_rvalid, spur, s_rvalid_in;

  assign s_rvalid_in = sl_rvalid | spur;

  axi_rd_arbiter #(.PRIO_MODE(0), .STARVE_MAX(4)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .m0_araddr(m0_araddr[0]), .m0_arvalid(m0_arvalid[0]), .m0_arready(m0_arready[0]),
    .m0_rdata(m0_rdata[0]), .m0_rvalid(m0_rvalid[0]), .m0_rready(m0_rready[0]),
    .m1_araddr(m1_araddr[0]), .m1_arvalid(m1_arvalid[0]), .m1_arready(m1_arready[0]),
    .m1_rdata(m1_rdata[0]), .m1_rvalid(m1_rvalid[0]), .m1_rready(m1_rready[0]),
    .s_araddr(s_araddr[0]), .s_arvalid(s_arvalid[0]), .s_arready(s_arready[0]),
    .s_rdata(sl_rdata[0]), .s_rvalid(s_rvalid_in[0]), .s_rready(s_rready[0])
  );

  axi_rd_arbiter #(.PRIO_MODE(1), .STARVE_MAX(2)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_araddr(m0_araddr[1]), .m0_arvalid(m0_arvalid[1]), .m0_arready(m0_arready[1]),
    .m0_rdata(m0_rdata[1]), .m0_rvalid(m0_rvalid[1]), .m0_rready(m0_rready[1]),
    .m1_araddr(m1_araddr[1]), .m1_arvalid(m1_arvalid[1]), .m1_arready(m1_arready[1]),
    .m1_rdata(m1_rdata[1]), .m1_rvalid(m1_rvalid[1]), .m1_rready(m1_rready[1]),
    .s_araddr(s_araddr[1]), .s_arvalid(s_arvalid[1]), .s_arready(s_arready[1]),
    .s_rdata(sl_rdata[1]), .s_rvalid(s_rvalid_in[1]), .s_rready(s_rready[1])
  );

  // Zero-wait read slave: response registered one cycle after the address handshake.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sl_rvalid <= '0;
      for (int k = 0; k < 2; k++) sl_rdata[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (s_arvalid[k] && s_arready[k]) begin
          sl_rvalid[k] <= 1'b1;
          sl_rdata[k]  <= 32'hA000_0000 + s_araddr[k];
        end else if (sl_rvalid[k] && s_rready[k]) begin
          sl_rvalid[k] <= 1'b0;
        end
      end
    end
  end

  typedef struct {
    int          k;
    logic        r0;
    logic [31:0] a0;
    logic        r1;
    logic [31:0] a1;
    int          g;
    logic [31:0] d;
  } vec_t;

  vec_t vt [17];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input int k, input string tag);
    chk({tag, " s_arvalid"}, 32'(s_arvalid[k]), 0);
    chk({tag, " s_araddr"}, s_araddr[k], 0);
    chk({tag, " s_rready"}, 32'(s_rready[k]), 0);
    chk({tag, " arready"}, 32'({m1_arready[k], m0_arready[k]}), 0);
    chk({tag, " rvalid"}, 32'({m1_rvalid[k], m0_rvalid[k]}), 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int c;
    int got;
    @(negedge clk);
    m0_arvalid[v.k] = v.r0; m0_araddr[v.k] = v.a0;
    m1_arvalid[v.k] = v.r1; m1_araddr[v.k] = v.a1;
    m0_rready[v.k] = 1'b1; m1_rready[v.k] = 1'b1;
    m0_arvalid[1-v.k] = 1'b0; m1_arvalid[1-v.k] = 1'b0;
    #1;
    c = 0;
    while (!(m0_arready[v.k] || m1_arready[v.k]) && c < 12) begin
      @(negedge clk); #1; c++;
    end
    got = m1_arready[v.k] ? 1 : (m0_arready[v.k] ? 0 : 9);
    chk($sformatf("v%0d grant", idx), 32'(got), 32'(v.g));
    @(negedge clk); #1;
    chk($sformatf("v%0d s_arvalid", idx), 32'(s_arvalid[v.k]), 1);
    chk($sformatf("v%0d s_araddr", idx), s_araddr[v.k], (v.g == 1) ? v.a1 : v.a0);
    @(negedge clk); #1;
    if (v.g == 1) begin
      chk($sformatf("v%0d m1_rvalid", idx), 32'(m1_rvalid[v.k]), 1);
      chk($sformatf("v%0d m1_rdata", idx), m1_rdata[v.k], v.d);
      chk($sformatf("v%0d m0_rvalid", idx), 32'(m0_rvalid[v.k]), 0);
    end else begin
      chk($sformatf("v%0d m0_rvalid", idx), 32'(m0_rvalid[v.k]), 1);
      chk($sformatf("v%0d m0_rdata", idx), m0_rdata[v.k], v.d);
      chk($sformatf("v%0d m1_rvalid", idx), 32'(m1_rvalid[v.k]), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{0, 1'b1, 32'h10, 1'b0, 32'h00, 0, 32'hA000_0010};
    vt[1]  = '{0, 1'b1, 32'h00, 1'b1, 32'h04, 1, 32'hA000_0004};
    vt[2]  = '{0, 1'b1, 32'h00, 1'b1, 32'h04, 0, 32'hA000_0000};
    vt[3]  = '{0, 1'b1, 32'h00, 1'b1, 32'h04, 1, 32'hA000_0004};
    vt[4]  = '{0, 1'b1, 32'h00, 1'b1, 32'h04, 0, 32'hA000_0000};
    vt[5]  = '{0, 1'b0, 32'h00, 1'b1, 32'h08, 1, 32'hA000_0008};
    vt[6]  = '{1, 1'b1, 32'h20, 1'b1, 32'h24, 1, 32'hA000_0024};
    vt[7]  = '{1, 1'b1, 32'h20, 1'b1, 32'h24, 1, 32'hA000_0024};
    vt[8]  = '{1, 1'b1, 32'h20, 1'b1, 32'h24, 0, 32'hA000_0020};
    vt[9]  = '{1, 1'b1, 32'h20, 1'b1, 32'h24, 1, 32'hA000_0024};
    vt[10] = '{1, 1'b1, 32'h20, 1'b1, 32'h24, 1, 32'hA000_0024};
    vt[11] = '{1, 1'b1, 32'h20, 1'b1, 32'h24, 0, 32'hA000_0020};
    vt[12] = '{1, 1'b1, 32'h30, 1'b0, 32'h00, 0, 32'hA000_0030};
    vt[13] = '{1, 1'b0, 32'h00, 1'b1, 32'h34, 1, 32'hA000_0034};
    vt[14] = '{1, 1'b1, 32'h38, 1'b1, 32'h3C, 1, 32'hA000_003C};
    vt[15] = '{1, 1'b1, 32'h38, 1'b1, 32'h3C, 1, 32'hA000_003C};
    vt[16] = '{1, 1'b1, 32'h38, 1'b1, 32'h3C, 0, 32'hA000_0038};

    rst_n = 1'b0;
    m0_arvalid = '0; m1_arvalid = '0; m0_rready = '0; m1_rready = '0;
    s_arready = 2'b11; spur = '0;
    for (int k = 0; k < 2; k++) begin
      m0_araddr[k] = '0; m1_araddr[k] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk_idle(0, "reset rr");
    chk_idle(1, "reset fp");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) run_vec(vt[i], i);

    @(negedge clk);
    m0_arvalid = '0; m1_arvalid = '0;
    repeat (4) @(negedge clk);

    // Backpressure: m1 stalls rready; pending m0 request must wait for the handshake.
    m1_arvalid[0] = 1'b1; m1_araddr[0] = 32'h40; m1_rready[0] = 1'b0; #1;
    chk("bp grant m1", 32'(m1_arready[0]), 1);
    @(negedge clk);
    m1_arvalid[0] = 1'b0; m0_arvalid[0] = 1'b1; m0_araddr[0] = 32'h44; #1;
    chk("bp m0 blocked addr", 32'(m0_arready[0]), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk($sformatf("bp%0d m1_rvalid", i), 32'(m1_rvalid[0]), 1);
      chk($sformatf("bp%0d m1_rdata", i), m1_rdata[0], 32'hA000_0040);
      chk($sformatf("bp%0d m0_arready", i), 32'(m0_arready[0]), 0);
      chk($sformatf("bp%0d s_rready", i), 32'(s_rready[0]), 0);
    end
    @(negedge clk);
    m1_rready[0] = 1'b1; #1;
    chk("bp s_rready", 32'(s_rready[0]), 1);
    chk("bp m0_arready held", 32'(m0_arready[0]), 0);
    @(negedge clk); #1;
    chk("bp m0 granted", 32'(m0_arready[0]), 1);
    @(negedge clk);
    m0_arvalid[0] = 1'b0; #1;
    chk("bp m0 s_araddr", s_araddr[0], 32'h44);
    @(negedge clk); #1;
    chk("bp m0_rvalid", 32'(m0_rvalid[0]), 1);
    chk("bp m0_rdata", m0_rdata[0], 32'hA000_0044);

    // Slave stalls s_arready for 3 cycles.
    @(negedge clk);
    s_arready[0] = 1'b0; m0_arvalid[0] = 1'b1; m0_araddr[0] = 32'h50; #1;
    chk("st grant m0", 32'(m0_arready[0]), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      m0_arvalid[0] = 1'b0; m1_arvalid[0] = 1'b1; m1_araddr[0] = 32'h54; #1;
      chk($sformatf("st%0d s_arvalid", i), 32'(s_arvalid[0]), 1);
      chk($sformatf("st%0d s_araddr", i), s_araddr[0], 32'h50);
      chk($sformatf("st%0d arready", i), 32'({m1_arready[0], m0_arready[0]}), 0);
    end
    @(negedge clk);
    s_arready[0] = 1'b1; #1;
    chk("st s_arvalid release", 32'(s_arvalid[0]), 1);
    @(negedge clk);
    m1_arvalid[0] = 1'b0; #1;
    chk("st m0_rvalid", 32'(m0_rvalid[0]), 1);
    chk("st m0_rdata", m0_rdata[0], 32'hA000_0050);
    chk("st m1_arready", 32'(m1_arready[0]), 0);

    // Spurious slave rvalid while idle must not reach either master.
    @(negedge clk);
    @(negedge clk);
    spur[0] = 1'b1; #1;
    chk("spur rvalid", 32'({m1_rvalid[0], m0_rvalid[0]}), 0);
    @(negedge clk);
    spur[0] = 1'b0;

    // Reset asserted while in S_ADDR.
    @(negedge clk);
    m0_arvalid[0] = 1'b1; m0_araddr[0] = 32'h60; #1;
    chk("rst pre grant m0", 32'(m0_arready[0]), 1);
    @(negedge clk);
    m0_arvalid[0] = 1'b0; #1;
    chk("rst pre s_arvalid", 32'(s_arvalid[0]), 1);
    rst_n = 1'b0; #1;
    chk_idle(0, "rst mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m0_arvalid[0] = 1'b1; m0_araddr[0] = 32'h70;
    m1_arvalid[0] = 1'b1; m1_araddr[0] = 32'h74; #1;
    chk("rst tie m0_arready", 32'(m0_arready[0]), 1);
    chk("rst tie m1_arready", 32'(m1_arready[0]), 0);
    @(negedge clk);
    m0_arvalid[0] = 1'b0; m1_arvalid[0] = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
